sm_regdump: RTL and testbench

Debug register-dump engine for the schoolMIPS core. On a start pulse it walks the core's debug register port (`regAddr` → `regData`), reading each register as the initiator/reader, and serializes the values as a framed byte stream on a valid/ready interface for a UART or trace sink. It sits beside `sm_cpu` in the top level, taking over `regAddr` while busy, and is the hardware counterpart of the bench-side register/PC monitor.

---
 rtl/sm_regdump_pkg.sv | 27 ++
 rtl/sm_regdump_ser.sv | 49 ++++
 rtl/sm_regdump.sv | 150 +++++++++++++++
 tb/tb_sm_regdump.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the sm_regdump register-dump engine.
// Build option: define SM_REGDUMP_CHECKSUM_EN to append an XOR checksum byte.
package sm_regdump_pkg;

  localparam int unsigned BYTES_PER_REG = 5;
  localparam logic [7:0]  SYNC_DEFAULT  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_LOAD,
    ST_SEND,
`ifdef SM_REGDUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

`ifdef SM_REGDUMP_CHECKSUM_EN
  // XOR of the five bytes of one {index, data} word
  function automatic logic [7:0] xor_fold(input logic [39:0] w);
    return w[39:32] ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
`endif

endpackage

// File: rtl/sm_regdump_ser.sv
// 40-bit parallel-load, MSB-first byte serializer with valid/ready handshake.
// i_single sends only the top byte (used for sync and checksum bytes).
module sm_regdump_ser
  import sm_regdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_single,
  input  logic [39:0] i_data,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last
);

  logic [39:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        r_single;
  logic        w_hs;
  logic [2:0]  w_final;

  assign w_hs    = r_valid & i_ready;
  assign w_final = r_single ? 3'd0 : 3'(BYTES_PER_REG - 1);
  assign o_last  = w_hs && (r_cnt == w_final);
  assign o_data  = r_shift[39:32];
  assign o_valid = r_valid;

  // A load on the same edge as the final handshake takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_single <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_data;
      r_cnt    <= '0;
      r_valid  <= 1'b1;
      r_single <= i_single;
    end else if (w_hs) begin
      r_shift <= {r_shift[31:0], 8'h00};
      r_cnt   <= r_cnt + 3'd1;
      if (o_last) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Debug register-dump engine: walks regAddr REG_FIRST..REG_LAST and streams a framed byte dump.
// Build option: SM_REGDUMP_CHECKSUM_EN appends the XOR of all bytes after the sync byte.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int unsigned REG_FIRST = 0,
  parameter int unsigned REG_LAST  = 31,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] IDX_FIRST = 5'(REG_FIRST);
  localparam logic [4:0] IDX_LAST  = 5'(REG_LAST);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_load, w_single, w_last;
  logic [39:0] w_ld_data;
  logic [39:0] w_word;
`ifdef SM_REGDUMP_CHECKSUM_EN
  logic [7:0]  r_csum, w_csum_nxt;
`endif

  assign w_word  = {3'b000, r_idx, regData};
  assign busy    = r_busy;
  assign done    = r_done;
  assign regAddr = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= IDX_FIRST;
      r_addr <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SM_REGDUMP_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_idx  <= w_idx_nxt;
      r_addr <= w_addr_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
`ifdef SM_REGDUMP_CHECKSUM_EN
      r_csum <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_single    = 1'b0;
    w_ld_data   = '0;
`ifdef SM_REGDUMP_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    unique case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_SYNC;
        w_load      = 1'b1;
        w_single    = 1'b1;
        w_ld_data   = {SYNC_BYTE, 32'h0};
        w_idx_nxt   = IDX_FIRST;
        w_busy_nxt  = 1'b1;
`ifdef SM_REGDUMP_CHECKSUM_EN
        w_csum_nxt  = '0;
`endif
      end
      ST_SYNC: if (w_last) begin
        w_state_nxt = ST_ADDR;
        w_addr_nxt  = r_idx;
      end
      ST_ADDR: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_state_nxt = ST_SEND;
        w_load      = 1'b1;
        w_ld_data   = w_word;
`ifdef SM_REGDUMP_CHECKSUM_EN
        w_csum_nxt  = r_csum ^ xor_fold(w_word);
`endif
      end
      // Checksum is folded at LOAD, so it is complete when the last word finishes
      ST_SEND: if (w_last) begin
        if (r_idx == IDX_LAST) begin
`ifdef SM_REGDUMP_CHECKSUM_EN
          w_state_nxt = ST_CSUM;
          w_load      = 1'b1;
          w_single    = 1'b1;
          w_ld_data   = {r_csum, 32'h0};
`else
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_addr_nxt  = '0;
`endif
        end else begin
          w_state_nxt = ST_ADDR;
          w_idx_nxt   = r_idx + 5'd1;
          w_addr_nxt  = r_idx + 5'd1;
        end
      end
`ifdef SM_REGDUMP_CHECKSUM_EN
      ST_CSUM: if (w_last) begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
        w_addr_nxt  = '0;
      end
`endif
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sm_regdump_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_single (w_single),
    .i_data   (w_ld_data),
    .i_ready  (tx_ready),
    .o_data   (tx_data),
    .o_valid  (tx_valid),
    .o_last   (w_last)
  );

endmodule

// File: tb/tb_sm_regdump.sv
// Scoreboard bench for sm_regdump: expected frames are built from a local register-file model.
module tb_sm_regdump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b1;
  logic        rnd_mode = 1'b0;
  logic [31:0] rf [32];

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        valid_a, valid_b, valid_c;
  logic [4:0]  addr_a, addr_b, addr_c;
  logic [7:0]  data_a, data_b, data_c;
  logic [31:0] rd_a, rd_b, rd_c;

  assign rd_a = rf[addr_a];
  assign rd_b = rf[addr_b];
  assign rd_c = rf[addr_c];

  sm_regdump u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .regAddr(addr_a), .regData(rd_a), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(tx_ready)
  );

  sm_regdump #(.REG_FIRST(2), .REG_LAST(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .regAddr(addr_b), .regData(rd_b), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(tx_ready)
  );

  sm_regdump #(.REG_FIRST(2), .REG_LAST(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .regAddr(addr_c), .regData(rd_c), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int   sel = 0;
  logic m_busy, m_done, m_valid;
  logic [4:0] m_addr;
  logic [7:0] m_data;

  always_comb begin
    m_busy = busy_a; m_done = done_a; m_valid = valid_a; m_addr = addr_a; m_data = data_a;
    case (sel)
      1: begin m_busy = busy_b; m_done = done_b; m_valid = valid_b; m_addr = addr_b; m_data = data_b; end
      2: begin m_busy = busy_c; m_done = done_c; m_valid = valid_c; m_addr = addr_c; m_data = data_c; end
      default: ;
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] rx_buf [16];
  int         rx_count = 0;
  logic       p_stall = 1'b0;
  logic [7:0] p_data = '0;

  task automatic push_frame(input int first, input int last);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    exp_q.push_back(8'hA5);
    for (int i = first; i <= last; i++) begin
      w = rf[i];
      exp_q.push_back(8'(i));
      cs ^= 8'(i);
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        cs ^= w[b*8 +: 8];
      end
    end
`ifdef SM_REGDUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  function automatic int frame_len(input int first, input int last);
    int n;
    n = 1 + 5 * (last - first + 1);
`ifdef SM_REGDUMP_CHECKSUM_EN
    n++;
`endif
    return n;
  endfunction

  // Scoreboard monitor: a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(p_data));
      end
      if (m_valid && tx_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 64'(exp_q.size()), 64'd1);
        else check("byte", 64'(m_data), 64'(exp_q.pop_front()));
        if (rx_count < 16) rx_buf[rx_count] = m_data;
        rx_count++;
      end
      p_stall = m_valid && !tx_ready;
      p_data  = m_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic set_start(input int s, input logic v);
    case (s)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  // Pulse start, then count edges from the start edge (edge 0 => cnt 1) until done
  task automatic run_dump(input int s, input int budget, output int done_at, output int ndone);
    int cnt;
    int tail;
    sel = s; ndone = 0; done_at = 0; tail = 0;
    @(posedge clk); #1;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    check("busy_after_start", 64'(m_busy), 64'd1);
    check("valid_after_start", 64'(m_valid), 64'd1);
    check("sync_byte", 64'(m_data), 64'hA5);
    cnt = 1;
    while (cnt < budget && tail < 20) begin
      if (m_done) begin
        ndone++;
        if (done_at == 0) begin
          done_at = cnt;
          check("busy_during_done", 64'(m_busy), 64'd1);
        end
      end
      if (done_at != 0 && cnt == done_at + 1) begin
        check("busy_falls", 64'(m_busy), 64'd0);
        check("done_one_cycle", 64'(m_done), 64'd0);
      end
      if (done_at != 0) tail++;
      @(posedge clk); #1;
      cnt++;
    end
    check("done_seen", 64'(done_at != 0), 64'd1);
    check("idle_after", 64'(m_busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  int d_at, n_done, k, exp_done;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[0] = 32'h0;

    #12;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Full default frame, ready held high
    rx_count = 0;
    push_frame(0, 31);
    run_dump(0, 400, d_at, n_done);
`ifdef SM_REGDUMP_CHECKSUM_EN
    exp_done = 227;
`else
    exp_done = 226;
`endif
    check("done_cycle", 64'(d_at), 64'(exp_done));
    check("done_count", 64'(n_done), 64'd1);
    check("byte_count", 64'(rx_count), 64'(frame_len(0, 31)));
    check("b1_sync", 64'(rx_buf[0]), 64'hA5);
    check("b2_idx0", 64'(rx_buf[1]), 64'h00);
    check("b7_idx1", 64'(rx_buf[6]), 64'h01);
    check("b8_r1msb", 64'(rx_buf[7]), 64'h10);
    check("b11_r1lsb", 64'(rx_buf[10]), 64'h01);

    // Sub-range frame
    rf[2] = 32'hDEAD_BEEF;
    rx_count = 0;
    push_frame(2, 3);
    run_dump(1, 200, d_at, n_done);
    check("b_byte_count", 64'(rx_count), 64'(frame_len(2, 3)));
    check("b_idx2", 64'(rx_buf[1]), 64'h02);
    check("b_de", 64'(rx_buf[2]), 64'hDE);
    check("b_ef", 64'(rx_buf[5]), 64'hEF);
    check("b_idx3", 64'(rx_buf[6]), 64'h03);

    // Single register, checksum case when enabled
    rf[2] = 32'h0102_0304;
    rx_count = 0;
    push_frame(2, 2);
    run_dump(2, 200, d_at, n_done);
    check("c_byte_count", 64'(rx_count), 64'(frame_len(2, 2)));
    check("c_b6", 64'(rx_buf[5]), 64'h04);
`ifdef SM_REGDUMP_CHECKSUM_EN
    check("c_csum", 64'(rx_buf[6]), 64'h06);
`endif

    // Random ready with a stray start at byte 40
    rf[2] = 32'h1000_0002;
    rnd_mode = 1'b1;
    rx_count = 0;
    push_frame(0, 31);
    fork
      run_dump(0, 2000, d_at, n_done);
      begin
        for (int w = 0; w < 3000 && rx_count < 40; w++) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
      end
    join
    check("rnd_done_count", 64'(n_done), 64'd1);
    check("rnd_byte_count", 64'(rx_count), 64'(frame_len(0, 31)));
    rnd_mode = 1'b0;

    // Reset in the middle of SEND for r10
    sel = 0;
    push_frame(0, 31);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    k = 0;
    while (k < 1000 && !(m_addr == 5'd10 && m_valid)) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_r10", 64'(k < 1000), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid_a), 64'd0);
    check("arst_busy", 64'(busy_a), 64'd0);
    check("arst_addr", 64'(addr_a), 64'd0);
    check("arst_data", 64'(data_a), 64'd0);
    exp_q.delete();
    #20;
    @(negedge clk); rst = 1'b0;
    rx_count = 0;
    push_frame(0, 31);
    run_dump(0, 400, d_at, n_done);
    check("post_rst_first", 64'(rx_buf[0]), 64'hA5);
    check("post_rst_count", 64'(rx_count), 64'(frame_len(0, 31)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
